mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_resp_lfsr.sv | 17 +
 rtl/mem_responder.sv | 104 ++++++++++
 tb/tb_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for mem_responder: FSM state encoding and the constants
// for the random-latency LFSR.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over q[15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mem_resp_lfsr.sv
// 16-bit Fibonacci LFSR with enable and synchronous reset to LFSR_SEED.
// Only instantiated when MEMRESP_RANDOM_LATENCY_EN is defined.
module mem_resp_lfsr
  import mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (res)     q <= LFSR_SEED;
    else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/mem_responder.sv
// Word-wide big-endian RAM target for the cache dbOut bus with a ready handshake
// and LATENCY wait states. MEMRESP_RANDOM_LATENCY_EN adds 0..3 LFSR-driven extra waits.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int LATENCY        = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic        db_re,
  input  logic        db_we,
  input  logic [31:0] db_addr,
  input  logic [31:0] db_dataOut,
  output logic [31:0] db_dataIn,
  output logic        db_ready
);

  localparam int WA = MEM_ADDR_WIDTH - 2;

  logic [31:0]   mem [0:(1<<WA)-1];
  state_t        state;
  logic [4:0]    cnt;
  logic [4:0]    lat_init;
  logic [WA-1:0] cap_addr;
  logic [31:0]   cap_data;
  logic          cap_we;

  logic          req;
  logic          commit;
  logic [WA-1:0] sel_addr;
  logic [31:0]   sel_data;
  logic          sel_we;

`ifdef MEMRESP_RANDOM_LATENCY_EN
  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  mem_resp_lfsr u_lfsr (
    .clk (clk),
    .res (res),
    .en  (1'b1),
    .q   (lfsr_q)
  );

  assign lat_init    = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
  assign unused_lfsr = ^lfsr_q[15:2];
`else
  assign lat_init = 5'(LATENCY);
`endif

  logic unused_addr;
  assign unused_addr = ^{db_addr[31:MEM_ADDR_WIDTH], db_addr[1:0]};

  assign req = db_re | db_we;

  // With zero total latency the access completes on the capture edge, so the
  // live bus values are used instead of the (not yet loaded) capture registers.
  assign sel_addr = (state == IDLE) ? db_addr[MEM_ADDR_WIDTH-1:2] : cap_addr;
  assign sel_data = (state == IDLE) ? db_dataOut : cap_data;
  assign sel_we   = (state == IDLE) ? db_we      : cap_we;
  assign commit   = !res && (((state == IDLE) && req && (lat_init == 5'd0)) ||
                             ((state == WAIT) && (cnt == 5'd1)));

  always_ff @(posedge clk) begin
    if (commit && sel_we) mem[sel_addr] <= sel_data;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      db_ready  <= 1'b0;
      db_dataIn <= 32'h0;
      cnt       <= 5'd0;
    end else begin
      db_ready <= 1'b0;
      if (commit && !sel_we) db_dataIn <= mem[sel_addr];
      case (state)
        IDLE: if (req) begin
          cap_addr <= db_addr[MEM_ADDR_WIDTH-1:2];
          cap_data <= db_dataOut;
          cap_we   <= db_we;
          if (lat_init == 5'd0) begin
            state    <= ACK;
            db_ready <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= lat_init;
          end
        end
        WAIT: if (cnt == 5'd1) begin
          state    <= ACK;
          cnt      <= 5'd0;
          db_ready <= 1'b1;
        end else begin
          cnt <= cnt - 5'd1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected read data and
// capture cycle, a negedge monitor pops and checks data and latency on db_ready.
module tb_mem_responder;
  localparam int MAW = 16;
  localparam int LAT = 2;

  logic        clk = 0;
  logic        res = 1;
  logic        db_re = 0, db_we = 0;
  logic [31:0] db_addr = 0, db_dataOut = 0;
  logic [31:0] db_dataIn;
  logic        db_ready;

  mem_responder #(.MEM_ADDR_WIDTH(MAW), .LATENCY(LAT)) dut (
    .clk(clk), .res(res), .db_re(db_re), .db_we(db_we), .db_addr(db_addr),
    .db_dataOut(db_dataOut), .db_dataIn(db_dataIn), .db_ready(db_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cap;
  } exp_t;

  exp_t        sb[$];
  int          lat_log[$];
  int          vectors = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          after_ack = 0;
  logic [31:0] model [int];
  logic [31:0] last_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (db_ready) begin
      if (sb.size() == 0) begin
        vectors++; fails++;
        $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        int   lat;
        bit   ok;
        e   = sb.pop_front();
        lat = cyc - e.cap;
        lat_log.push_back(lat);
        vectors++;
        if (db_dataIn !== e.data) begin
          fails++;
          $display("FAIL read_data: got %h expected %h", db_dataIn, e.data);
        end
`ifdef MEMRESP_RANDOM_LATENCY_EN
        ok = (lat >= LAT) && (lat <= LAT + 3);
`else
        ok = (lat == LAT);
`endif
        vectors++;
        if (!ok) begin
          fails++;
          $display("FAIL latency: got %0d edges expected %0d(+0..3 if random)", lat, LAT);
        end
      end
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a[MAW-1:2]);
  endfunction

  // Called at a negedge. hold keeps the request asserted through ACK so the
  // next call captures two edges later, as a streaming initiator would.
  task automatic access(input bit re, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    exp_t e;
    bit   seen = 0;
    db_re = re; db_we = we; db_addr = a; db_dataOut = d;
    e.cap = after_ack ? cyc + 2 : cyc + 1;
    if (we) begin
      model[widx(a)] = d;
      e.data = last_rd;
    end else begin
      e.data  = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
      last_rd = e.data;
    end
    sb.push_back(e);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = db_ready;
    end
    if (!seen) begin
      vectors++; fails++;
      $display("FAIL ready_timeout: got no ready expected one for addr %h", a);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    if (hold) after_ack = 1;
    else begin
      db_re = 0; db_we = 0;
      @(negedge clk);
      after_ack = 0;
    end
  endtask

  task automatic do_reset();
    res = 1; db_re = 0; db_we = 0;
    repeat (2) @(negedge clk);
    res = 0;
    last_rd = 0;
    after_ack = 0;
  endtask

  int run_a[$];

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_ready", {31'h0, db_ready}, 32'h0);
    check("reset_dataIn", db_dataIn, 32'h0);

    for (int w = 1; w < 17; w++) access(0, 1, w * 4, $urandom, 0);

    access(0, 1, 32'h100, 32'hDEADBEEF, 0);
    access(1, 0, 32'h100, 32'h0, 0);
    check("byte_100", {24'h0, dut.mem[16'h40][31:24]}, 32'hDE);
    check("byte_101", {24'h0, dut.mem[16'h40][23:16]}, 32'hAD);
    check("byte_102", {24'h0, dut.mem[16'h40][15:8]},  32'hBE);
    check("byte_103", {24'h0, dut.mem[16'h40][7:0]},   32'hEF);

    access(1, 0, 32'h102, 32'h0, 0);
    access(0, 1, 32'h10000, 32'h1, 0);
    access(1, 0, 32'h0, 32'h0, 0);
    access(1, 1, 32'h40, 32'h0BADC0DE, 0);
    check("rw_hold_dataIn", db_dataIn, 32'h1);

    access(1, 0, 32'h0, 32'h0, 1);
    access(1, 0, 32'h4, 32'h0, 1);
    access(1, 0, 32'h8, 32'h0, 0);

    // Reset during WAIT must drop the write and never raise ready.
    db_we = 1; db_addr = 32'h20; db_dataOut = 32'hCAFEF00D;
    @(negedge clk);
    res = 1; db_we = 0;
    @(negedge clk);
    res = 0; last_rd = 0;
    check("abort_dataIn", db_dataIn, 32'h0);
    repeat (6) @(negedge clk);
    access(1, 0, 32'h20, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      bit          we;
      a  = {14'($urandom_range(0, 3)), 18'h0} | (32'($urandom_range(0, 16)) << 2) |
           32'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      access(we ? 1'($urandom_range(0, 1)) : 1'b1, we, a, $urandom, 1'($urandom_range(0, 1)));
    end
    if (after_ack) begin db_re = 0; db_we = 0; @(negedge clk); after_ack = 0; end

    // Two identical runs from reset must produce identical latency sequences.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      lat_log.delete();
      for (int k = 0; k < 8; k++) access(1, 0, k * 4, 32'h0, 0);
      if (r == 0) run_a = lat_log;
    end
    for (int k = 0; k < 8; k++)
      check("lat_repeat", (k < lat_log.size()) ? lat_log[k] : -1,
            (k < run_a.size()) ? run_a[k] : -2);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1);
  end
endmodule
